// File: rtl/noc_input_unit.sv
// Input-port flit FIFO with XY route compute at enqueue.
// Presents the head flit's route and data to the output mux controller.
module noc_input_unit #(
   parameter int DATAW = 16,
   parameter int DEPTH = 4,
   parameter int XW    = 2,
   parameter int YW    = 2,
   parameter int MY_X  = 0,
   parameter int MY_Y  = 0
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATAW-1:0]           in_data,
   output logic                       req,
   output logic [2:0]                 port,
   output logic [DATAW-1:0]           out_data,
   input  logic                       grt,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATAW + 3;

   localparam logic [XW-1:0] MX       = XW'(MY_X);
   localparam logic [YW-1:0] MY       = YW'(MY_Y);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [2:0] P_LOCAL = 3'd0;
   localparam logic [2:0] P_NORTH = 3'd1;
   localparam logic [2:0] P_EAST  = 3'd2;
   localparam logic [2:0] P_SOUTH = 3'd3;
   localparam logic [2:0] P_WEST  = 3'd4;

   logic [EW-1:0] mem_q [DEPTH];
   logic [EW-1:0] mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push;
   logic          pop;
   logic [EW-1:0] head;

   function automatic logic [2:0] route_of(input logic [DATAW-1:0] d);
      logic [XW-1:0] dx;
      logic [YW-1:0] dy;
      logic [2:0]    r;
      dx = d[DATAW-1 -: XW];
      dy = d[DATAW-1-XW -: YW];
      r  = P_LOCAL;
      unique case (1'b1)
         (dx > MX):                r = P_EAST;
         (dx < MX):                r = P_WEST;
         (dx == MX) && (dy > MY):  r = P_NORTH;
         (dx == MX) && (dy < MY):  r = P_SOUTH;
         (dx == MX) && (dy == MY): r = P_LOCAL;
      endcase
      return r;
   endfunction

   assign in_ready = (count_q != FULL_CNT);
   assign req      = (count_q != '0);
   assign count    = count_q;
   assign push     = in_valid && in_ready;
   assign pop      = req && grt;
   assign head     = mem_q[rd_ptr_q];

   // Outputs are forced to zero when empty so stale storage never leaks out.
   assign port     = req ? head[EW-1 -: 3] : 3'd0;
   assign out_data = req ? head[DATAW-1:0] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push) begin
         mem_d[wr_ptr_q] = {route_of(in_data), in_data};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: doc/noc_input_unit.md
Name: noc_input_unit

Overview:
Per-input-port buffering and route-compute stage of the 5x5 mesh router. It sits directly upstream of the output-port mux controller. It accepts single-flit packets from a link or the local core into a small FIFO. It computes the XY output port for each flit at enqueue, then presents req/port for the head flit to the mux controller and pops the head when granted. Five instances per router feed the req_N/port_N inputs of each muxcont.

Parameters:
DATAW, 16, flit width in bits; destination fields sit in the MSBs.
DEPTH, 4, FIFO depth in flits; power of 2, minimum 2.
XW, 2, width of destination X field, in_data[DATAW-1 -: XW].
YW, 2, width of destination Y field, in_data[DATAW-1-XW -: YW].
MY_X, 0, this router's X coordinate.
MY_Y, 0, this router's Y coordinate.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_  input  1  reset; synchronous, active-high (rst_=1 resets on the next rising clk edge).
in_valid  input  1  upstream flit valid.
in_ready  output  1  space available; equals !full.
in_data  input  DATAW  incoming flit.
req  output  1  head flit present, requesting an output port.
port  output  3  output port of the head flit: 0=local, 1=north, 2=east, 3=south, 4=west.
out_data  output  DATAW  head flit data.
grt  input  1  grant for this input from the downstream mux controller.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {route[2:0], data[DATAW-1:0]}.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH. count is a separate register.
- Push: occurs when in_valid && in_ready. The write is at wr_ptr, which then increments.
- Pop: occurs when req && grt. rd_ptr increments. grt is ignored when req=0.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged. Legal only when not full; no push is accepted when full, even if a pop happens that cycle.
- Derived signals: in_ready = (count != DEPTH); req = (count != 0). Both are driven from registers only; there is no combinational path from grt or in_valid to any output.
- port and out_data show the head entry while req=1. Both are 0 when empty.
- Route compute, done at push from in_data; dx/dy are unsigned:
  - dx > MY_X -> 2 (east)
  - dx < MY_X -> 4 (west)
  - dx == MY_X and dy > MY_Y -> 1 (north)
  - dx == MY_X and dy < MY_Y -> 3 (south)
  - dx == MY_X and dy == MY_Y -> 0 (local)
- Latency: a flit pushed at edge N gives req=1 after edge N into an empty FIFO. Minimum enqueue-to-pop is 1 cycle, with grt high in the cycle after the push.
- Hold rule: while req=1 and grt=0, port and out_data are stable. Pushes behind the head never change them.
- Ordering: strict FIFO; no reordering.
- Reset: count=0, wr_ptr=0, rd_ptr=0, req=0, port=0, out_data=0, in_ready=1.
  - Storage contents are not reset.
  - Reset mid-operation discards all buffered flits. A concurrent in_valid or grt in the reset cycle has no effect.
- Full: in_valid is held off by in_ready=0 and any flit offered is not captured.
- Empty: grt is ignored and count never underflows.

Test Plan:
(All scenarios: MY_X=1, MY_Y=1, DATAW=16, DEPTH=4.)
1. Reset check: hold rst_=1 for 2 cycles with in_valid=1 and grt=1 -> count=0, req=0, port=0, out_data=0, in_ready=1 after reset.
2. Routing: push 0x5ABC, 0x9000, 0x1000, 0x6000 with grt=0, then grt=1 for 4 cycles -> port sequence 0,2,4,1 with out_data in order. Then push 0x4000 -> port=3.
3. Full: push 5 flits with grt=0 -> count=4, in_ready=0 after the 4th. The 5th is not stored. One grant -> count=3, in_ready=1.
4. Simultaneous push/pop: with count=2 and grt=1, push 0x9123 -> count stays 2, head advances, 0x9123 appears two pops later with port=2.
5. Hold and spurious grant: grt=1 while empty -> count stays 0. Push 0x1000 and hold grt=0 for 3 cycles -> req=1, port=4, out_data=0x1000, all constant.
6. Reset mid-operation: with count=3, assert rst_ for 1 cycle -> req=0, count=0. The next push of 0x5ABC shows port=0 and out_data=0x5ABC.
